// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: datapath hazard sources in, pipeline control word out.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles/flush_count counters.
// master = datapath side (drives hazard sources), slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_redirect;
   logic                  mdu_start;
   logic                  mdu_done;
   logic                  mem_busy;
   logic                  pc_en;
   logic [3:0]            stage_en;
   logic [3:0]            stage_clear;
   logic                  stall_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_count;
`endif

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
      output ex_redirect, mdu_start, mdu_done, mem_busy,
      input  pc_en, stage_en, stage_clear, stall_timeout
`ifdef HAZARD_PERF_CNT_EN
      ,
      input  stall_cycles, flush_count
`endif
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
      input  ex_redirect, mdu_start, mdu_done, mem_busy,
      output pc_en, stage_en, stage_clear, stall_timeout
`ifdef HAZARD_PERF_CNT_EN
      ,
      output stall_cycles, flush_count
`endif
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: merges load-use, EX redirect, multi-cycle MDU and
// data-memory wait into one per-cycle control word (pc_en, stage_en, stage_clear)
// for the IF/ID(0), ID/EX(1), EX/MEM(2), MEM/WB(3) registers.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall_cycles / flush_count counters).
// Handshake: there is no valid/ready pair; the control word is valid every cycle
// and is consumed by the pipeline registers on the same rising edge. Hazard sources
// (ex_redirect, mdu_done, mdu_start) stay stable while the pipe is frozen by mem_busy.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W       = 5,
   parameter int MAX_STALL_CYCLES = 255
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W            = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_hazard_ctrl_if.slave  hz,
   output logic [1:0]             dbg_state_o
);
   typedef enum logic [1:0] {S_INIT, S_RUN, S_MDU_WAIT, S_MEM_WAIT} state_t;

   localparam int SCW = $clog2(MAX_STALL_CYCLES + 1);

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;      // state to resume after a memory freeze
   state_t           eff_state;         // state whose rules apply this cycle
   logic [SCW-1:0]   cnt_q, cnt_d;
   logic             in_wait;
   logic             load_use;
   logic             redirect_taken;
   logic             pc_en;
   logic [3:0]       stage_en;
   logic [3:0]       stage_clear;

   // Load in EX writing a register the ID instruction reads (x0 never hazards).
   assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_ADDR_W'(0)) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // On the release cycle of a memory freeze, the interrupted state's rules apply.
   assign eff_state = (state_q == S_MEM_WAIT) ? ret_q : state_q;

   // Next state and control word; priority mem_busy > MDU wait > redirect > load-use.
   always_comb begin
      state_d        = state_q;
      ret_d          = ret_q;
      pc_en          = 1'b1;
      stage_en       = 4'b1111;
      stage_clear    = 4'b0000;
      redirect_taken = 1'b0;
      if (state_q == S_INIT) begin
         pc_en       = 1'b0;
         stage_clear = 4'b1111;
         state_d     = S_RUN;
      end else if (hz.mem_busy) begin
         pc_en    = 1'b0;
         stage_en = 4'b0000;
         state_d  = S_MEM_WAIT;
         ret_d    = eff_state;
      end else begin
         case (eff_state)
            S_MDU_WAIT: begin
               if (hz.mdu_done) begin
                  state_d = S_RUN;
               end else begin
                  pc_en       = 1'b0;
                  stage_en    = 4'b1100;
                  stage_clear = 4'b0100;
                  state_d     = S_MDU_WAIT;
               end
            end
            default: begin
               state_d = hz.mdu_start ? S_MDU_WAIT : S_RUN;
               if (hz.ex_redirect) begin
                  stage_clear    = 4'b0011;
                  redirect_taken = 1'b1;
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  stage_en    = 4'b1110;
                  stage_clear = 4'b0010;
               end
            end
         endcase
      end
   end

   // Consecutive wait cycles, saturating so the timeout pulses once per wait episode.
   assign in_wait = (state_q == S_MDU_WAIT) || (state_q == S_MEM_WAIT);

   always_comb begin
      cnt_d = '0;
      if (in_wait) begin
         cnt_d = (cnt_q == SCW'(MAX_STALL_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // State, resume state and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ret_q   <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.pc_en         = pc_en;
   assign hz.stage_en      = stage_en;
   assign hz.stage_clear   = stage_clear;
   assign hz.stall_timeout = in_wait && (cnt_q == SCW'(MAX_STALL_CYCLES - 1));
   assign dbg_state_o      = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] flush_count_q;

   // Performance counters; idle during INIT, wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else if (state_q != S_INIT) begin
         if (!pc_en) stall_cycles_q <= stall_cycles_q + 1'b1;
         if (redirect_taken) flush_count_q <= flush_count_q + 1'b1;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model through an expected queue.
module tb_pipeline_hazard_ctrl;
   localparam int MAXS = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz();

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MAX_STALL_CYCLES(MAXS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz          (hz),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // expected word: {pc_en, stage_en[3:0], stage_clear[3:0], stall_timeout}
   logic [9:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_init_pending = 1'b1;
   bit m_mdu_active   = 1'b0;  // an MDU op sits in EX awaiting its result
   bit m_prev_busy    = 1'b0;  // previous cycle was a memory freeze
   int m_wait_cnt     = 0;     // consecutive wait cycles so far
   int busy_left      = 0;

   // Evaluate one cycle of the reference model on the current inputs and queue the word.
   task automatic model_cycle();
      logic       pc;
      logic [3:0] en, cl;
      logic       to;
      bit         lu, waiting;
      int         cur;
      pc = 1'b1; en = 4'hF; cl = 4'h0; to = 1'b0;
      if (!rst_n || m_init_pending) begin
         exp_q.push_back({1'b0, 4'hF, 4'hF, 1'b0});
         m_init_pending = !rst_n;
         m_mdu_active   = 1'b0;
         m_prev_busy    = 1'b0;
         m_wait_cnt     = 0;
         return;
      end
      waiting    = m_mdu_active || m_prev_busy;
      cur        = waiting ? m_wait_cnt + 1 : 0;
      to         = (cur == MAXS);
      m_wait_cnt = cur;
      lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
           ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
      if (hz.mem_busy) begin
         pc = 1'b0; en = 4'h0;
         m_prev_busy = 1'b1;
      end else begin
         m_prev_busy = 1'b0;
         if (m_mdu_active) begin
            if (hz.mdu_done) m_mdu_active = 1'b0;
            else begin pc = 1'b0; en = 4'b1100; cl = 4'b0100; end
         end else begin
            if (hz.ex_redirect) cl = 4'b0011;
            else if (lu) begin pc = 1'b0; en = 4'b1110; cl = 4'b0010; end
            if (hz.mdu_start) m_mdu_active = 1'b1;
         end
      end
      exp_q.push_back({pc, en, cl, to});
   endtask

   // driver tasks
   task automatic begin_cycle();
      @(negedge clk);
      hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
      hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_redirect = 1'b0;
      hz.mdu_start = 1'b0; hz.mdu_done = 1'b0; hz.mem_busy = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin begin_cycle(); model_cycle(); end
   endtask

   task automatic load_use_cycle(input logic [4:0] rd, input logic redir);
      begin_cycle();
      hz.ex_mem_read = 1'b1; hz.ex_rd = rd; hz.id_use_rs2 = 1'b1; hz.id_rs2 = 5'd5;
      hz.ex_redirect = redir;
      model_cycle();
   endtask

   task automatic mdu_wait_cycles(input int n, input logic busy);
      for (int i = 0; i < n; i++) begin
         begin_cycle(); hz.mem_busy = busy; model_cycle();
      end
   endtask

   task automatic rand_cycle();
      bit hold;
      hold = (busy_left > 0);
      @(negedge clk);
      if (hold) begin
         busy_left--;
         hz.mem_busy = 1'b1;
      end else begin
         if ($urandom_range(0, 11) == 0) begin
            busy_left   = $urandom_range(0, 9);
            hz.mem_busy = 1'b1;
         end else hz.mem_busy = 1'b0;
         hz.id_rs1      = 5'($urandom_range(0, 3));
         hz.id_rs2      = 5'($urandom_range(0, 3));
         hz.ex_rd       = 5'($urandom_range(0, 3));
         hz.id_use_rs1  = 1'($urandom_range(0, 1));
         hz.id_use_rs2  = 1'($urandom_range(0, 1));
         hz.ex_mem_read = 1'($urandom_range(0, 1));
         hz.ex_redirect = ($urandom_range(0, 5) == 0);
         hz.mdu_start   = !m_mdu_active && ($urandom_range(0, 9) == 0);
         hz.mdu_done    = m_mdu_active && (hz.mdu_done || $urandom_range(0, 4) == 0);
      end
      model_cycle();
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cycle(); rst_n = 1'b0; model_cycle();
      end
      begin_cycle(); rst_n = 1'b1; model_cycle();
   endtask

   // scoreboard monitor: compare the presented control word against the queue
   initial begin
      logic [9:0] exp, act;
      forever begin
         @(negedge clk);
         #3;
         while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {hz.pc_en, hz.stage_en, hz.stage_clear, hz.stall_timeout};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL ctrl_word t=%0t got pc=%b en=%b clr=%b to=%b want pc=%b en=%b clr=%b to=%b",
                        $time, act[9], act[8:5], act[4:1], act[0], exp[9], exp[8:5], exp[4:1], exp[0]);
            end
         end
      end
   end

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      rst_n = 1'b0;
      do_reset(3);
      idle_cycles(2);
      load_use_cycle(5'd5, 1'b0);  // one bubble
      idle_cycles(1);
      load_use_cycle(5'd0, 1'b0);  // x0 never stalls
      load_use_cycle(5'd5, 1'b1);  // redirect overrides load-use
      idle_cycles(1);
      begin_cycle(); hz.mdu_start = 1'b1; model_cycle();
      mdu_wait_cycles(6, 1'b0);
      begin_cycle(); hz.mdu_done = 1'b1; model_cycle();
      idle_cycles(1);
      begin_cycle(); hz.mdu_start = 1'b1; model_cycle();
      mdu_wait_cycles(1, 1'b0);
      mdu_wait_cycles(3, 1'b1);    // freeze inside MDU wait
      mdu_wait_cycles(2, 1'b0);
      begin_cycle(); hz.mdu_done = 1'b1; model_cycle();
      idle_cycles(2);
      for (int i = 0; i < 10; i++) begin
         begin_cycle(); hz.mem_busy = 1'b1; model_cycle();
      end
      idle_cycles(3);
      // reset in the middle of a stall
      for (int i = 0; i < 3; i++) begin
         begin_cycle(); hz.mem_busy = 1'b1; model_cycle();
      end
      do_reset(1);
      idle_cycles(2);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 600; i++) rand_cycle();
         busy_left = 0;
         do_reset($urandom_range(1, 3));
      end
      idle_cycles(2);
      @(negedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain left=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
